// File: rtl/stream_uart_pkg.sv
// Shared definitions for the stream UART receive path: FSM encodings,
// baud-rate arithmetic, the end-of-line marker and the FIFO beat layout.
package stream_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam logic [7:0] EOL = 8'h0A;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } rx_beat_t;

    // Smallest width able to index v values; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/stream_uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Simultaneous push and pop are both honoured, including when full.
module stream_uart_rx_fifo
    import stream_uart_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full_c
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_q, wr_q, rd_d, wr_d;
    logic             empty, do_push, do_pop, valid_d;
    logic [WIDTH-1:0] dout_d;

    assign empty  = (rd_q == wr_q);
    assign full_c = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);

    // Next pointers and next head word; a push into an emptying FIFO bypasses to the head.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full_c || do_pop);
        rd_d    = rd_q + PW'(do_pop);
        wr_d    = wr_q + PW'(do_push);
        valid_d = (rd_d != wr_d);
        dout_d  = dout;
        if (valid_d) begin
            if (do_push && (rd_d[AW-1:0] == wr_q[AW-1:0])) dout_d = din;
            else                                           dout_d = mem[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            dout  <= dout_d;
            valid <= valid_d;
        end
    end

endmodule

// File: rtl/stream_uart_rx.sv
// 8N1 UART receiver feeding a byte stream with end-of-line tlast marking,
// buffered by a small FWFT FIFO; reports framing errors and overruns.
module stream_uart_rx
    import stream_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 16000000,
    parameter int unsigned BAUD     = 57600,
    parameter int unsigned DEPTH    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CW  = clog2(CPB);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CPB - 1);

    logic [1:0]    sync_q;
    logic          rxs;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          push_c, frame_err_c, overrun_c, pop_c, full_c;
    rx_beat_t      beat_c, head;

    assign rxs    = sync_q[1];
    assign pop_c  = o_tvalid && i_tready;
    assign beat_c = '{last: (sh_q == EOL), data: sh_q};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], i_uart_rx};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            o_frame_err <= frame_err_c;
            o_overrun   <= overrun_c;
        end
    end

    // Frame sequencing: every sample point is where the baud counter reaches zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        push_c      = 1'b0;
        frame_err_c = 1'b0;
        overrun_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    cnt_d   = HALF_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rxs) begin
                    cnt_d   = FULL_LOAD;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    sh_d  = {rxs, sh_q[7:1]};
                    cnt_d = FULL_LOAD;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    if (!full_c || pop_c) push_c = 1'b1;
                    else                  overrun_c = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    frame_err_c = 1'b1;
                    state_d     = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    stream_uart_rx_fifo #(
        .WIDTH ($bits(rx_beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .push   (push_c),
        .din    (beat_c),
        .pop    (pop_c),
        .dout   (head),
        .valid  (o_tvalid),
        .full_c (full_c)
    );

    assign o_tdata = head.data;
    assign o_tlast = head.last;

endmodule

// File: tb/tb_stream_uart_rx.sv
// Directed/randomised bench for stream_uart_rx against a queue-based
// reference model of the received byte stream and error pulses.
module tb_stream_uart_rx;

    localparam int unsigned CLK_FREQ = 16000000;
    localparam int unsigned BAUD     = 57600;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CPB      = (CLK_FREQ + BAUD / 2) / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart = 1'b1;
    logic       tready = 1'b0;
    logic [7:0] tdata;
    logic       tlast, tvalid, frame_err, overrun;

    stream_uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_uart_rx   (uart),
        .o_tdata     (tdata),
        .o_tlast     (tlast),
        .o_tvalid    (tvalid),
        .i_tready    (tready),
        .o_frame_err (frame_err),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Passive observation of handshakes and pulses.
    int         cyc = 0;
    logic [8:0] rx_q[$];
    int         ferr_cnt = 0, ovr_cnt = 0, valid_cycles = 0, rise_cyc = 0;
    int         coincide = 0, long_pulse = 0, stab_err = 0;
    logic       prev_valid = 1'b0, prev_stall = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
    logic [8:0] prev_head = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tvalid && tready) rx_q.push_back({tlast, tdata});
        if (tvalid) valid_cycles++;
        if (tvalid && !prev_valid) rise_cyc = cyc;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) coincide++;
        if ((frame_err && prev_ferr) || (overrun && prev_ovr)) long_pulse++;
        if (prev_stall && tvalid && ({tlast, tdata} !== prev_head)) stab_err++;
        prev_valid = tvalid;
        prev_stall = tvalid && !tready;
        prev_head  = {tlast, tdata};
        prev_ferr  = frame_err;
        prev_ovr   = overrun;
    end

    // Reference model: bytes the consumer should see, and expected error counts.
    logic [8:0] exp_q[$];
    logic [8:0] mfifo[$];
    int         exp_ferr = 0, exp_ovr = 0;
    bit         m_hold = 0;

    task automatic model_frame(input logic [7:0] b, input bit good);
        logic [8:0] beat;
        beat = {(b == 8'h0A), b};
        if (!good)                      exp_ferr++;
        else if (!m_hold)               exp_q.push_back(beat);
        else if (mfifo.size() < DEPTH)  mfifo.push_back(beat);
        else                            exp_ovr++;
    endtask

    task automatic model_release();
        while (mfifo.size() > 0) exp_q.push_back(mfifo.pop_front());
        m_hold = 0;
    endtask

    int n_tests = 0, n_fail = 0;
    int last_start = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart = 1'b0;
        last_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart = stop;
        repeat (CPB) @(negedge clk);
        if (stop) uart = 1'b1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    int         base_rx, base_ferr, base_ovr, base_vc, lat, nominal;
    logic [7:0] rb;
    logic [8:0] r0, r1;

    initial begin
        // Reset state
        idle(3);
        #1;
        check("reset_tvalid", 32'(tvalid), 0);
        check("reset_tdata", 32'(tdata), 0);
        check("reset_tlast", 32'(tlast), 0);
        check("reset_errs", 32'({frame_err, overrun}), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        tready = 1'b1;
        idle(10);

        // Single frame 0x55 with latency and one-cycle valid
        base_rx = rx_q.size(); base_vc = valid_cycles;
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1);
        idle(CPB);
        check("single_count", 32'(rx_q.size() - base_rx), 1);
        check("single_beat", 32'(rx_q[base_rx]), 32'(9'h055));
        check("single_valid_cycles", 32'(valid_cycles - base_vc), 1);
        lat = rise_cyc - last_start;
        nominal = int'(CPB * 19 / 2) + 2;
        check("single_latency_window", 32'((lat >= nominal - 3) && (lat <= nominal + 3)), 1);

        // "A\n" back to back
        base_rx = rx_q.size(); base_ferr = ferr_cnt; base_ovr = ovr_cnt;
        send_frame(8'h41, 1'b1); model_frame(8'h41, 1);
        send_frame(8'h0A, 1'b1); model_frame(8'h0A, 1);
        idle(CPB);
        check("eol_count", 32'(rx_q.size() - base_rx), 2);
        r0 = (rx_q.size() > base_rx) ? rx_q[base_rx] : 9'h1FF;
        r1 = (rx_q.size() > base_rx + 1) ? rx_q[base_rx + 1] : 9'h1FF;
        check("eol_first", 32'(r0), 32'(9'h041));
        check("eol_second", 32'(r1), 32'(9'h10A));
        check("eol_no_errors", 32'((ferr_cnt - base_ferr) + (ovr_cnt - base_ovr)), 0);

        // Back-pressure and overrun
        tready = 1'b0; m_hold = 1;
        base_rx = rx_q.size(); base_ovr = ovr_cnt;
        for (int i = 1; i <= 6; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1);
        end
        idle(CPB);
        check("ovr_pulses", 32'(ovr_cnt - base_ovr), 32'(exp_ovr));
        check("ovr_pulse_count_two", 32'(ovr_cnt - base_ovr), 2);
        check("ovr_head_held", 32'({tvalid, tlast, tdata}), 32'(10'h201));
        check("ovr_nothing_consumed", 32'(rx_q.size() - base_rx), 0);
        @(negedge clk);
        tready = 1'b1; model_release();
        idle(10);
        check("ovr_drained_valid", 32'(tvalid), 0);
        check("ovr_drained_count", 32'(rx_q.size() - base_rx), 4);
        for (int i = 0; i < 4; i++) begin
            r0 = (rx_q.size() > base_rx + i) ? rx_q[base_rx + i] : 9'h1FF;
            check("ovr_drained_byte", 32'(r0), 32'(i + 1));
        end

        // Framing error, line held low, then recovery
        base_rx = rx_q.size(); base_ferr = ferr_cnt;
        send_frame(8'hA5, 1'b0); model_frame(8'hA5, 0);
        idle(20 * CPB);
        uart = 1'b1;
        idle(2 * CPB);
        check("frame_err_pulses", 32'(ferr_cnt - base_ferr), 1);
        check("frame_no_output", 32'(rx_q.size() - base_rx), 0);
        send_frame(8'h3C, 1'b1); model_frame(8'h3C, 1);
        idle(CPB);
        r0 = (rx_q.size() > base_rx) ? rx_q[base_rx] : 9'h1FF;
        check("frame_recover_byte", 32'(r0), 32'(9'h03C));

        // Glitch rejection
        base_rx = rx_q.size(); base_ferr = ferr_cnt; base_ovr = ovr_cnt;
        @(negedge clk); uart = 1'b0;
        idle(CPB / 4);
        uart = 1'b1;
        idle(3 * CPB);
        check("glitch_no_output", 32'(rx_q.size() - base_rx), 0);
        check("glitch_no_errors", 32'((ferr_cnt - base_ferr) + (ovr_cnt - base_ovr)), 0);
        rb = 8'($urandom);
        send_frame(rb, 1'b1); model_frame(rb, 1);
        idle(CPB);
        r0 = (rx_q.size() > base_rx) ? rx_q[base_rx] : 9'h1FF;
        check("glitch_then_byte", 32'(r0), 32'({(rb == 8'h0A), rb}));

        // Random bytes with a free-flowing consumer
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1); model_frame(rb, 1);
        end
        idle(CPB);

        // Async reset mid-frame with two bytes queued
        tready = 1'b0; m_hold = 1;
        rb = 8'($urandom);
        send_frame(rb, 1'b1); model_frame(rb, 1);
        send_frame(8'($urandom), 1'b1);
        @(negedge clk); uart = 1'b0;
        idle(4 * CPB);
        check("pre_reset_head", 32'({tvalid, tlast, tdata}), 32'({1'b1, (rb == 8'h0A), rb}));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({tvalid, tlast, tdata, frame_err, overrun}), 0);
        mfifo.delete(); m_hold = 0;
        idle(3);
        uart = 1'b1;
        idle(2);
        rst_n = 1'b1; tready = 1'b1;
        idle(10);
        base_rx = rx_q.size();
        send_frame(8'h7E, 1'b1); model_frame(8'h7E, 1);
        idle(CPB);
        check("post_reset_count", 32'(rx_q.size() - base_rx), 1);
        r0 = (rx_q.size() > base_rx) ? rx_q[base_rx] : 9'h1FF;
        check("post_reset_byte", 32'(r0), 32'(9'h07E));

        // Whole-run scoreboard and pulse hygiene
        check("stream_length", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check("stream_beat", 32'(rx_q[i]), 32'(exp_q[i]));
        check("total_frame_err", 32'(ferr_cnt), 32'(exp_ferr));
        check("total_overrun", 32'(ovr_cnt), 32'(exp_ovr));
        check("pulse_coincide", 32'(coincide), 0);
        check("pulse_width", 32'(long_pulse), 0);
        check("axi_stability", 32'(stab_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
